// File: rtl/mod3_stream_acc.sv
// Frame-level modulo-3 accumulator fed by per-byte remainders; emits frame remainder and length.
// Optional MOD3_CHECK_EN macro adds err_o flagging illegal remainder code 3 within a frame.
module mod3_stream_acc #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       rem_i,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic [1:0]       rem_o,
  output logic [CNT_W-1:0] len_o,
  output logic             ovf_o,
`ifdef MOD3_CHECK_EN
  output logic             err_o,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]       rem;
    logic [CNT_W-1:0] len;
    logic             ovf;
  } result_t;

  state_e           state_q, state_d;
  logic [1:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  result_t          res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             beat_acc;
  logic             res_take;
  logic             frame_start;
  logic [1:0]       rem_clean;
  logic [1:0]       acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic             ovf_base;
  logic             sat_hit;
  logic [1:0]       acc_sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_sum;

`ifdef MOD3_CHECK_EN
  logic err_q, err_d;
  logic err_res_q, err_res_d;
  logic err_sum;
`endif

  // Sum of two residues in 0..2, folded back into 0..2.
  function automatic logic [1:0] mod3add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = 3'(a) + 3'(b);
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Datapath: the beat's contribution, with frame-start reseeding the running values.
  always_comb begin
    beat_acc    = in_valid_i && in_ready_q;
    res_take    = out_valid_q && out_ready_i;
    frame_start = (state_q == IDLE);
    rem_clean   = (rem_i == 2'd3) ? 2'd0 : rem_i;
    acc_base    = frame_start ? 2'd0 : acc_q;
    cnt_base    = frame_start ? '0 : cnt_q;
    ovf_base    = frame_start ? 1'b0 : ovf_q;
    sat_hit     = (cnt_base == CNT_MAX);
    acc_sum     = mod3add(acc_base, rem_clean);
    cnt_inc     = sat_hit ? cnt_base : CNT_W'(cnt_base + CNT_W'(1));
    ovf_sum     = ovf_base | sat_hit;
  end

`ifdef MOD3_CHECK_EN
  always_comb begin
    err_sum = ((state_q == IDLE) ? 1'b0 : err_q) | (rem_i == 2'd3);
  end
`endif

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef MOD3_CHECK_EN
    err_d       = err_q;
    err_res_d   = err_res_q;
`endif
    case (state_q)
      IDLE, ACCUM: begin
        if (beat_acc) begin
          if (in_last_i) begin
            state_d     = HOLD;
            res_d.rem   = acc_sum;
            res_d.len   = cnt_inc;
            res_d.ovf   = ovf_sum;
            acc_d       = 2'd0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
`ifdef MOD3_CHECK_EN
            err_res_d   = err_sum;
            err_d       = 1'b0;
`endif
          end else begin
            state_d = ACCUM;
            acc_d   = acc_sum;
            cnt_d   = cnt_inc;
            ovf_d   = ovf_sum;
`ifdef MOD3_CHECK_EN
            err_d   = err_sum;
`endif
          end
        end
      end
      HOLD: begin
        if (res_take) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        acc_d       = 2'd0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      acc_q       <= 2'd0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef MOD3_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q     <= 1'b0;
      err_res_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      err_res_q <= err_res_d;
    end
  end

  assign err_o = err_res_q;
`endif

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign rem_o       = res_q.rem;
  assign len_o       = res_q.len;
  assign ovf_o       = res_q.ovf;

endmodule

// File: tb/tb_mod3_stream_acc.sv
// Self-checking bench for mod3_stream_acc: directed frames plus randomized frames against a frame-level model.
module tb_mod3_stream_acc;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       rem_in;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [1:0]       rem_out;
  logic [CNT_W-1:0] len_out;
  logic             ovf_out;
  logic             out_valid;
  logic             out_ready;
`ifdef MOD3_CHECK_EN
  logic             err_out;
`endif

  int checks = 0;
  int errors = 0;
  int frame_q[$];

  always #5 clk = ~clk;

  mod3_stream_acc #(.CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .rem_i       (rem_in),
    .in_valid_i  (in_valid),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .rem_o       (rem_out),
    .len_o       (len_out),
    .ovf_o       (ovf_out),
`ifdef MOD3_CHECK_EN
    .err_o       (err_out),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame result from arithmetic on the whole frame: illegal code 3 contributes nothing.
  task automatic model(output logic [1:0] r, output logic [CNT_W-1:0] l,
                       output logic o, output logic e);
    int s;
    int n;
    s = 0;
    e = 1'b0;
    n = frame_q.size();
    foreach (frame_q[i]) begin
      if (frame_q[i] == 3) e = 1'b1;
      else s += frame_q[i];
    end
    r = 2'(s % 3);
    l = (n > int'(MAXC)) ? CNT_W'(MAXC) : CNT_W'(n);
    o = (n > int'(MAXC));
  endtask

  task automatic wait_accept();
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=in_ready_low expected=in_ready_high");
    end
    @(negedge clk);
  endtask

  // Send every beat of frame_q, with optional idle cycles between beats.
  task automatic play_beats(input int stall_pct, input bit send_last);
    int n;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < 32'(stall_pct)) begin
        in_valid = 1'b0;
        rem_in   = 2'($urandom_range(3));
        @(negedge clk);
      end
      in_valid = 1'b1;
      rem_in   = 2'(frame_q[i]);
      in_last  = send_last && (i == n - 1);
      wait_accept();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input int bp, input bit keep_valid);
    logic [1:0]       er;
    logic [CNT_W-1:0] el;
    logic             eo;
    logic             ee;
    model(er, el, eo, ee);
    chk({tag, "_valid"}, 32'(out_valid), 32'(1));
    chk({tag, "_rem"},   32'(rem_out),   32'(er));
    chk({tag, "_len"},   32'(len_out),   32'(el));
    chk({tag, "_ovf"},   32'(ovf_out),   32'(eo));
`ifdef MOD3_CHECK_EN
    chk({tag, "_err"},   32'(err_out),   32'(ee));
`endif
    chk({tag, "_rdy_hold"}, 32'(in_ready), 32'(0));
    for (int c = 0; c < bp; c++) begin
      out_ready = 1'b0;
      in_valid  = keep_valid;
      rem_in    = 2'd1;
      in_last   = 1'b0;
      @(negedge clk);
      chk({tag, "_bp_valid"}, 32'(out_valid), 32'(1));
      chk({tag, "_bp_rem"},   32'(rem_out),   32'(er));
      chk({tag, "_bp_len"},   32'(len_out),   32'(el));
      chk({tag, "_bp_ovf"},   32'(ovf_out),   32'(eo));
      chk({tag, "_bp_rdy"},   32'(in_ready),  32'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_post_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_post_rdy"},   32'(in_ready),  32'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"},   32'(in_ready),  32'(1));
    chk({tag, "_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_rem"},   32'(rem_out),   32'(0));
    chk({tag, "_len"},   32'(len_out),   32'(0));
    chk({tag, "_ovf"},   32'(ovf_out),   32'(0));
`ifdef MOD3_CHECK_EN
    chk({tag, "_err"},   32'(err_out),   32'(0));
`endif
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    rem_in    = 2'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-byte frame.
    frame_q = '{2};
    play_beats(0, 1'b1);
    check_result("single", 0, 1'b0);

    // Number 0x01_00_FF, then a second multi-byte frame.
    frame_q = '{1, 0, 0};
    play_beats(0, 1'b1);
    check_result("multi3", 0, 1'b0);
    frame_q = '{2, 2, 2, 1};
    play_beats(0, 1'b1);
    check_result("multi4", 0, 1'b0);

    // Backpressure with upstream holding the next beat valid.
    frame_q = '{1, 1};
    play_beats(0, 1'b1);
    check_result("bp", 5, 1'b1);
    frame_q = '{2, 1};
    play_beats(0, 1'b1);
    check_result("after_bp", 0, 1'b0);

    // Input stalls between beats.
    frame_q = '{2, 1, 2};
    play_beats(60, 1'b1);
    check_result("stall", 2, 1'b0);

    // Counter saturation, then a short frame clears the overflow flag.
    frame_q = {};
    for (int i = 0; i < 20; i++) frame_q.push_back(1);
    play_beats(0, 1'b1);
    check_result("sat", 1, 1'b0);
    frame_q = '{1, 1};
    play_beats(0, 1'b1);
    check_result("post_sat", 0, 1'b0);

    // Illegal code contributes zero.
    frame_q = '{3, 1};
    play_beats(0, 1'b1);
    check_result("illegal", 0, 1'b0);
    frame_q = '{1};
    play_beats(0, 1'b1);
    check_result("post_illegal", 0, 1'b0);

    // Reset mid-frame discards the partial frame.
    frame_q = '{1, 1};
    play_beats(0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame_q = '{2};
    play_beats(0, 1'b1);
    check_result("after_rst", 0, 1'b0);

    // Reset while a result is pending.
    frame_q = '{1, 2, 1};
    play_beats(0, 1'b1);
    chk("pre_rst_hold_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized frames, lengths spanning the saturation point.
    for (int f = 0; f < 30; f++) begin
      n = int'($urandom_range(1, 20));
      frame_q = {};
      for (int i = 0; i < n; i++) frame_q.push_back(int'($urandom_range(3)));
      play_beats(int'($urandom_range(40)), 1'b1);
      check_result("rand", int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
